ifq_line_fetch_ctrl: RTL and testbench

Parametrised successor to the fixed 4-word fetch-queue controller. It sequences cache line requests and streams WORDS_PER_LINE words per line into the instruction FIFO, and tracks FIFO occupancy internally. A new line is started only when the FIFO has room for the whole line. New behaviour over the previous block:
- cache handshake using dout_valid;
- true bypass of the FIFO when it is empty;
- branch flush.

It sits between the PC/I-cache and the instruction FIFO of the fetch stage.

---
 rtl/ifq_line_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_ifq_line_fetch_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifq_line_fetch_ctrl.sv
// ifq_line_fetch_ctrl
//   Fetch-stage line sequencer. It requests one cache line at a time and
//   streams WORDS_PER_LINE words into the instruction FIFO. It also tracks
//   FIFO occupancy locally, so a line is only requested once the FIFO can
//   take all of it. When the FIFO is empty and decode is reading, a word
//   bypasses the FIFO and goes straight to decode. A branch redirect drops
//   everything queued or in flight.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   dout_valid        cache line data valid (looked at only while requesting)
//   rd_enable         decode wants one instruction this cycle
//   branch_valid      redirect: discard queued and in-flight words
//   cache_en          line request, high for the whole request state
//   word_sel          word index within the line being delivered
//   push_fifo/bypass  deliver selected word into FIFO / straight to decode
//   pop_fifo          FIFO read strobe
//   flush_fifo        one-cycle FIFO clear
//   line_adv          one-cycle PC advance by one line
//   fifo_count/empty/full  tracked FIFO occupancy
module ifq_line_fetch_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_W          = $clog2(FIFO_DEPTH + 1),
  parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dout_valid,
  input  logic             rd_enable,
  input  logic             branch_valid,
  output logic             cache_en,
  output logic [IDX_W-1:0] word_sel,
  output logic             push_fifo,
  output logic             bypass,
  output logic             pop_fifo,
  output logic             flush_fifo,
  output logic             line_adv,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_empty,
  output logic             fifo_full
);

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_REQ, S_STREAM, S_FLUSH
  } state_e;

  // Highest occupancy that still leaves room for a complete line.
  localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(FIFO_DEPTH - WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliver;

  always_comb begin
    // A branch cancels whatever the current stream cycle would deliver.
    deliver    = (state_q == S_STREAM) && !branch_valid;
    bypass     = deliver && (cnt_q == '0) && rd_enable;
    push_fifo  = deliver && !bypass;
    line_adv   = deliver && (idx_q == LAST_IDX);
    pop_fifo   = rd_enable && (cnt_q != '0) && (state_q != S_FLUSH) && !branch_valid;
    cache_en   = (state_q == S_REQ);
    flush_fifo = (state_q == S_FLUSH);
    word_sel   = idx_q;
    fifo_count = cnt_q;
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));

    if (state_q == S_FLUSH) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(push_fifo) - CNT_W'(pop_fifo);

    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_RST: state_d = S_IDLE;
      S_IDLE: begin
        if (branch_valid)         state_d = S_FLUSH;
        else if (cnt_q <= ROOM_MAX) state_d = S_REQ;
      end
      S_REQ: begin
        if (branch_valid) state_d = S_FLUSH;
        else if (dout_valid) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (branch_valid) begin
          state_d = S_FLUSH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;  // wraps to 0 after the last word
          // Room for the next line is judged on the post-update count.
          if (idx_q == LAST_IDX) state_d = (cnt_d <= ROOM_MAX) ? S_REQ : S_IDLE;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifq_line_fetch_ctrl.sv
module tb_ifq_line_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // default instance: 4 words/line, 16 entries
  logic       rst1 = 1'b0, dv1 = 1'b0, rd1 = 1'b0, br1 = 1'b0;
  logic       ce1, pu1, by1, po1, fl1, la1, em1, fu1;
  logic [1:0] ws1;
  logic [4:0] cnt1;

  ifq_line_fetch_ctrl dut1 (
    .clk(clk), .reset(rst1), .dout_valid(dv1), .rd_enable(rd1), .branch_valid(br1),
    .cache_en(ce1), .word_sel(ws1), .push_fifo(pu1), .bypass(by1), .pop_fifo(po1),
    .flush_fifo(fl1), .line_adv(la1), .fifo_count(cnt1), .fifo_empty(em1), .fifo_full(fu1)
  );

  // wide-line instance: 8 words/line, 8 entries
  logic       rst2 = 1'b0, dv2 = 1'b0, rd2 = 1'b0, br2 = 1'b0;
  logic       ce2, pu2, by2, po2, fl2, la2, em2, fu2;
  logic [2:0] ws2;
  logic [3:0] cnt2;

  ifq_line_fetch_ctrl #(.WORDS_PER_LINE(8), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .reset(rst2), .dout_valid(dv2), .rd_enable(rd2), .branch_valid(br2),
    .cache_en(ce2), .word_sel(ws2), .push_fifo(pu2), .bypass(by2), .pop_fifo(po2),
    .flush_fifo(fl2), .line_adv(la2), .fifo_count(cnt2), .fifo_empty(em2), .fifo_full(fu2)
  );

  typedef struct {
    bit rs, dv, rd, br;
    bit ce, pu, by, po, fl, la;
    int ws, cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rs, bit dv, bit rd, bit br, bit ce, int ws,
                              bit pu, bit by, bit po, bit fl, bit la, int cnt);
    vec_t v;
    v.rs = rs; v.dv = dv; v.rd = rd; v.br = br;
    v.ce = ce; v.ws = ws; v.pu = pu; v.by = by; v.po = po; v.fl = fl; v.la = la;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(int which, int idx, bit ce, int ws, bit pu, bit by, bit po,
                         bit fl, bit la, int cnt);
    if (which == 1) begin
      chk("dut1.cache_en", idx, ce1, ce);   chk("dut1.word_sel", idx, ws1, ws);
      chk("dut1.push", idx, pu1, pu);       chk("dut1.bypass", idx, by1, by);
      chk("dut1.pop", idx, po1, po);        chk("dut1.flush", idx, fl1, fl);
      chk("dut1.line_adv", idx, la1, la);   chk("dut1.count", idx, cnt1, cnt);
      chk("dut1.empty", idx, em1, cnt == 0); chk("dut1.full", idx, fu1, cnt == 16);
    end else begin
      chk("dut2.cache_en", idx, ce2, ce);   chk("dut2.word_sel", idx, ws2, ws);
      chk("dut2.push", idx, pu2, pu);       chk("dut2.bypass", idx, by2, by);
      chk("dut2.pop", idx, po2, po);        chk("dut2.flush", idx, fl2, fl);
      chk("dut2.line_adv", idx, la2, la);   chk("dut2.count", idx, cnt2, cnt);
      chk("dut2.empty", idx, em2, cnt == 0); chk("dut2.full", idx, fu2, cnt == 8);
    end
  endtask

  // dut2 step: drive, check after settle, advance one clock
  int s2 = 0;
  task automatic step2(bit rs, bit dv, bit rd, bit br, bit ce, int ws, bit pu,
                       bit by, bit po, bit fl, bit la, int cnt);
    rst2 = rs; dv2 = dv; rd2 = rd; br2 = br;
    #1;
    chk_all(2, s2, ce, ws, pu, by, po, fl, la, cnt);
    s2++;
    @(posedge clk); #1;
  endtask

  // occupancy bound, checked on every falling edge once running
  bit mon_on = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      tests++;
      if (cnt1 > 5'd16 || cnt2 > 4'd8) begin
        fails++;
        $display("FAIL count_bound: got %0d/%0d limit 16/8", cnt1, cnt2);
      end
    end
  end

  initial begin
    // reset, then REQ held 4 cycles before dout_valid
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0,0));      // RST
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0,0));      // IDLE
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,0,0, 1,0,0,0,0,0,0,0));
    // four lines with no reads fill the FIFO to 16
    for (int l = 0; l < 4; l++) begin
      vecs.push_back(mk(1,1,0,0, 1,0,0,0,0,0,0,4*l));   // REQ, data valid
      for (int i = 0; i < 4; i++)
        vecs.push_back(mk(1,1,0,0, 0,i,1,0,0,0,(i==3),4*l+i));
    end
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,0,0,0,16));     // IDLE, full
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,0,0,0,16));
    // four pops: 16 -> 12
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1,0,1,0, 0,0,0,0,1,0,0,16-k));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0,12));     // IDLE, room now
    vecs.push_back(mk(1,1,0,0, 1,0,0,0,0,0,0,12));     // REQ
    for (int i = 0; i < 4; i++)                        // push+pop hold 12
      vecs.push_back(mk(1,1,1,0, 0,i,1,0,1,0,(i==3),12));
    vecs.push_back(mk(1,0,0,1, 1,0,0,0,0,0,0,12));     // REQ cancelled by branch
    vecs.push_back(mk(1,0,1,0, 0,0,0,0,0,1,0,12));     // FLUSH, no pop
    vecs.push_back(mk(1,0,1,0, 0,0,0,0,0,0,0,0));      // IDLE, empty read ignored
    vecs.push_back(mk(1,1,1,0, 1,0,0,0,0,0,0,0));      // REQ
    for (int i = 0; i < 4; i++)                        // bypass whole line
      vecs.push_back(mk(1,0,1,0, 0,i,0,1,0,0,(i==3),0));
    // build count 6 at word 1 of a line
    vecs.push_back(mk(1,1,0,0, 1,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0, 0,i,1,0,0,0,(i==3),i));
    vecs.push_back(mk(1,1,0,0, 1,0,0,0,0,0,0,4));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0, 0,i,1,0,0,0,(i==3),4+i));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,1,0, 1,0,0,0,1,0,0,8-k));
    vecs.push_back(mk(1,1,0,0, 1,0,0,0,0,0,0,5));
    vecs.push_back(mk(1,0,0,0, 0,0,1,0,0,0,0,5));      // word 0
    vecs.push_back(mk(1,0,1,1, 0,1,0,0,0,0,0,6));      // word 1 + branch
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,1,0,6));      // FLUSH
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0,0));      // IDLE
    vecs.push_back(mk(1,1,0,0, 1,0,0,0,0,0,0,0));      // REQ
    vecs.push_back(mk(1,0,0,0, 0,0,1,0,0,0,0,0));      // word 0
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0,0));      // async reset mid-line

    mon_on = 1'b1;
    foreach (vecs[n]) begin
      rst1 = vecs[n].rs; dv1 = vecs[n].dv; rd1 = vecs[n].rd; br1 = vecs[n].br;
      #1;
      chk_all(1, n, vecs[n].ce, vecs[n].ws, vecs[n].pu, vecs[n].by, vecs[n].po,
              vecs[n].fl, vecs[n].la, vecs[n].cnt);
      @(posedge clk); #1;
    end

    // wide line, FIFO holds exactly one line
    step2(0,0,0,0, 0,0,0,0,0,0,0,0);
    step2(1,0,0,0, 0,0,0,0,0,0,0,0);                   // RST
    step2(1,0,0,0, 0,0,0,0,0,0,0,0);                   // IDLE
    step2(1,1,0,0, 1,0,0,0,0,0,0,0);                   // REQ
    for (int i = 0; i < 8; i++) step2(1,0,0,0, 0,i,1,0,0,0,(i==7),i);
    step2(1,0,0,0, 0,0,0,0,0,0,0,8);                   // IDLE, full
    for (int k = 0; k < 7; k++) step2(1,0,1,0, 0,0,0,0,1,0,0,8-k);
    step2(1,1,0,0, 0,0,0,0,0,0,0,1);                   // count 1: no REQ
    step2(1,1,1,0, 0,0,0,0,1,0,0,1);
    step2(1,0,0,0, 0,0,0,0,0,0,0,0);                   // IDLE at 0 -> REQ
    step2(1,1,0,0, 1,0,0,0,0,0,0,0);
    step2(1,0,0,0, 0,0,1,0,0,0,0,0);
    rst2 = 1'b1; dv2 = 1'b0; rd2 = 1'b0; br2 = 1'b0;
    #1;
    chk_all(2, s2, 0,1,1,0,0,0,0,1);                   // word 1 before reset
    #2;
    rst2 = 1'b0;                                       // async, mid-cycle
    #1;
    chk_all(2, s2 + 1, 0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    chk_all(2, s2 + 2, 0,0,0,0,0,0,0,0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
